// File: rtl/pc_pkg.sv
// pc_pkg: next-address operation encodings and shared width defaults for pc_ras.
package pc_pkg;
    localparam int ADDR_SZ = 6;
    localparam int RAS_DEPTH = 4;
    typedef enum logic [2:0] {
        INC  = 3'd0,
        REL  = 3'd1,
        ABS  = 3'd2,
        CALL = 3'd3,
        RET  = 3'd4
    } pc_op_t;
endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular-pointer return-address LIFO that drops the oldest entry when pushed while full.
module ras_stack #(
    parameter int AddrSz = 6,
    parameter int Depth = 4,
    localparam int PtrW = $clog2(Depth),
    localparam int CntW = $clog2(Depth + 1)
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              push,
    input  logic              pop,
    input  logic [AddrSz-1:0] push_data,
    output logic [AddrSz-1:0] top,
    output logic [CntW-1:0]   count
);
    logic [AddrSz-1:0] mem_q [Depth];
    logic [PtrW-1:0]   ptr_q, ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    // ptr_q is the next write slot; wrapping it over the oldest entry implements drop-oldest
    always_comb begin
        ptr_d   = push ? ptr_q + PtrW'(1) : pop ? ptr_q - PtrW'(1) : ptr_q;
        count_d = push ? (count_q == CntW'(Depth) ? count_q : count_q + CntW'(1))
                : pop ? count_q - CntW'(1) : count_q;
    end
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[ptr_q] <= push_data;
    end
    assign top   = mem_q[ptr_q - PtrW'(1)];
    assign count = count_q;
endmodule

// File: rtl/pc_ras.sv
// pc_ras: program counter with INC/REL/ABS/CALL/RET next-address selection, return stack and sticky error flags.
module pc_ras
    import pc_pkg::*;
#(
    parameter int AddrSz = ADDR_SZ,
    parameter int Depth = RAS_DEPTH
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              en,
    input  pc_op_t            op,
    input  logic [AddrSz-1:0] offset,
    input  logic [AddrSz-1:0] target,
    input  logic              err_clr,
    output logic [AddrSz-1:0] addr,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              overflow,
    output logic              underflow
);
    localparam int CntW = $clog2(Depth + 1);
    logic [AddrSz-1:0] addr_q, addr_d, inc, top;
    logic [CntW-1:0]   count;
    logic              overflow_q, overflow_d, underflow_q, underflow_d;
    logic              push, pop, is_call, is_ret;
    assign stack_empty = count == '0;
    assign stack_full  = count == CntW'(Depth);
    always_comb begin
        is_call     = en && op == CALL;
        is_ret      = en && op == RET;
        push        = is_call;
        pop         = is_ret && !stack_empty;
        inc         = addr_q + AddrSz'(1);
        addr_d      = !en ? addr_q
                    : op == REL ? addr_q + offset
                    : (op == ABS || op == CALL) ? target
                    : pop ? top : inc;
        // a new error wins over a simultaneous clear
        overflow_d  = (is_call && stack_full) || (overflow_q && !err_clr);
        underflow_d = (is_ret && stack_empty) || (underflow_q && !err_clr);
    end
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            addr_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end
    ras_stack #(.AddrSz(AddrSz), .Depth(Depth)) u_stack (
        .clk       (clk),
        .n_reset   (n_reset),
        .push      (push),
        .pop       (pop),
        .push_data (inc),
        .top       (top),
        .count     (count)
    );
    assign addr      = addr_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
endmodule

// File: doc/pc_ras.md
PC_RAS -- requirements
Module: pc_ras

Interface
REQ-001 SHALL have parameter AddrSz, default 6, instruction address width in bits.
REQ-002 SHALL have parameter Depth, default 4, return-address stack entries; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-004 SHALL have port n_reset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  advance; low holds all state.
REQ-006 SHALL have port op  input  pc_op_t (3)  next-address operation: INC, REL, ABS, CALL, RET.
REQ-007 SHALL have port offset  input  AddrSz  two's-complement relative offset for REL.
REQ-008 SHALL have port target  input  AddrSz  absolute destination for ABS and CALL.
REQ-009 SHALL have port err_clr  input  1  clears sticky error flags.
REQ-010 SHALL have port addr  output  AddrSz  current instruction address (registered).
REQ-011 SHALL have port stack_empty  output  1  no valid return entries.
REQ-012 SHALL have port stack_full  output  1  Depth valid entries.
REQ-013 SHALL have port overflow  output  1  sticky: CALL issued while full.
REQ-014 SHALL have port underflow  output  1  sticky: RET issued while empty.

Function
REQ-015 SHALL, with en low, hold addr, stack contents, count and flags; only err_clr acts.
REQ-016 SHALL, with en high, update addr one cycle after the op is sampled (latency 1), all arithmetic modulo 2^AddrSz.
REQ-017 INC: addr <= addr + 1; wraps from 2^AddrSz-1 to 0.
REQ-018 REL: addr <= addr + offset, offset sign-interpreted (e.g. 6'b111110 = -2); wrap permitted, no flag.
REQ-019 ABS: addr <= target; stack untouched.
REQ-020 CALL: push (addr + 1) mod 2^AddrSz, addr <= target, count increments.
REQ-021 CALL while full: push still occurs, overwriting the oldest entry (circular buffer), count stays Depth, overflow set.
REQ-022 RET while non-empty: addr <= top entry, pop, count decrements.
REQ-023 RET while empty: addr <= addr + 1 (treated as INC), stack unchanged, underflow set.
REQ-024 stack_empty = (count == 0), stack_full = (count == Depth), both combinational from registered count.
REQ-025 overflow/underflow SHALL remain set until err_clr high on a clock edge; if clear and a new error occur in the same cycle, the flag SHALL be set.
REQ-026 Undefined op encodings SHALL behave as INC.

Reset
REQ-027 Asserting n_reset SHALL immediately (asynchronously) force addr = 0, count = 0, overflow = 0, underflow = 0; stack_empty = 1, stack_full = 0.
REQ-028 Stack entry storage need not be reset; entries SHALL never be observable while count excludes them.
REQ-029 Reset asserted mid-sequence (e.g. during nested CALLs) SHALL discard all return addresses; first post-reset edge with en high and op INC yields addr = 1.

Structure
REQ-030 Package pc_pkg SHALL hold typedef enum pc_op_t {INC=0, REL=1, ABS=2, CALL=3, RET=4} and any shared address-width constants.
REQ-031 Return stack SHALL be a sub-module ras_stack (parameters AddrSz, Depth; push, pop, push_data, top, count), circular-pointer LIFO with drop-oldest on overflow.
REQ-032 pc_ras SHALL contain only next-address selection, addr register and sticky flags.

Verification
REQ-033 Reset, en=1, op=INC x3 -> addr 1, 2, 3; en=0 two cycles -> addr holds 3.
REQ-034 AddrSz=6, addr=2, op=REL offset=6'b111110 -> addr 0; addr=62, INC x2 -> 63, 0.
REQ-035 addr=5, CALL target=20 -> addr 20, stack_empty 0; CALL target=40 -> addr 40; RET -> 41... no: RET -> addr 21; RET -> addr 6, stack_empty 1.
REQ-036 Depth=4: five CALLs from addr 0 with targets 10,20,30,40,50 -> stack_full 1, overflow 1; five RETs -> 41, 31, 21, 11, then underflow 1 and addr 12.
REQ-037 underflow set, err_clr=1 same cycle as another empty RET -> underflow stays 1; next cycle err_clr=1, op=INC -> underflow 0.
REQ-038 Two CALLs then n_reset pulsed asynchronously between edges -> addr 0, stack_empty 1 immediately; RET after release -> addr 1, underflow 1.
